// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types for the MEM-stage SRAM controller: FSM states, access op and phase-counter width.
package sram_mem_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

    typedef enum logic {OP_RD, OP_WR} op_e;

    // Wide enough for ACCESS_CYCLES up to 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/sram_rd_buf.sv
// One-entry word buffer for the SRAM controller: holds the last word read and tracks writes to it.
// Only instantiated when SRAM_MEM_CTRL_RD_BUF_EN is defined.
module sram_rd_buf #(
    parameter int unsigned TAG_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [31:0]      hit_data,
    input  logic             done_en,
    input  logic             done_wr,
    input  logic [TAG_W-1:0] done_tag,
    input  logic [31:0]      done_data
);

    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      data_q;

    assign hit      = valid_q && (tag_q == lookup_tag);
    assign hit_data = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (done_en) begin
            if (!done_wr) begin
                valid_q <= 1'b1;
                tag_q   <= done_tag;
                data_q  <= done_data;
            end else if (valid_q && (tag_q == done_tag)) begin
                // Keep the buffered copy coherent with the word just stored.
                data_q <= done_data;
            end
        end
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller splitting 32-bit loads/stores into two halfword accesses on a 16-bit async
// SRAM. Define SRAM_MEM_CTRL_RD_BUF_EN to add a one-entry read buffer that short-circuits reloads.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int unsigned ADDR_W        = 18,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_we_n
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ACCESS_CYCLES - 1);

    state_e            state;
    op_e               op_q;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-2:0] word_q;
    logic [31:0]       wdata_q;

    logic              req;
    op_e               req_op;
    logic [31:0]       addr_off;
    logic [ADDR_W-2:0] req_word;
    logic              last;
    logic              buf_hit;
    logic [31:0]       buf_data;
    logic              unused_off;

    assign req        = rd_en | wr_en;
    assign req_op     = wr_en ? OP_WR : OP_RD;
    assign addr_off   = addr - BASE_ADDR;
    assign req_word   = addr_off[ADDR_W:2];
    assign unused_off = ^{addr_off[31:ADDR_W+1], addr_off[1:0]};
    assign last       = (cnt == LastCnt);

`ifdef SRAM_MEM_CTRL_RD_BUF_EN
    sram_rd_buf #(
        .TAG_W(ADDR_W - 1)
    ) u_rd_buf (
        .clk       (clk),
        .rst       (rst),
        .lookup_tag(req_word),
        .hit       (buf_hit),
        .hit_data  (buf_data),
        .done_en   (state == DONE),
        .done_wr   (op_q == OP_WR),
        .done_tag  (word_q),
        .done_data ((op_q == OP_WR) ? wdata_q : rdata)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_RD;
            cnt         <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        op_q    <= req_op;
                        word_q  <= req_word;
                        wdata_q <= wdata;
                        cnt     <= '0;
                        if (req_op == OP_RD && buf_hit) begin
                            state <= DONE;
                            rdata <= buf_data;
                        end else begin
                            state       <= LO;
                            sram_addr   <= {req_word, 1'b0};
                            sram_dq_out <= wdata[15:0];
                            sram_dq_oe  <= wr_en;
                            sram_we_n   <= ~wr_en;
                        end
                    end
                end
                LO: begin
                    if (last) begin
                        state       <= HI;
                        cnt         <= '0;
                        sram_addr   <= {word_q, 1'b1};
                        sram_dq_out <= wdata_q[31:16];
                        if (op_q == OP_RD) rdata[15:0] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HI: begin
                    if (last) begin
                        state      <= DONE;
                        cnt        <= '0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        if (op_q == OP_RD) rdata[31:16] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ready = 1'b0;
        unique case (state)
            IDLE:    ready = ~req;
            LO, HI:  ready = 1'b0;
            DONE:    ready = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: a driver issues loads/stores against a word-level reference
// memory, and a monitor checks each completed access against the expected response.
module tb_sram_mem_ctrl;

    localparam int unsigned AW = 18;
    localparam int unsigned AC = 2;
`ifdef SRAM_MEM_CTRL_RD_BUF_EN
    localparam bit BufEn = 1'b1;
`else
    localparam bit BufEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;

    always #5 clk = ~clk;

    sram_mem_ctrl #(
        .BASE_ADDR    (32'd1024),
        .ADDR_W       (AW),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n)
    );

    // Behavioural async SRAM: write while we_n is low, read combinationally.
    logic [15:0] sram_mem [0:(1<<AW)-1];
    bit          sram_live = 1'b0;
    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) if (sram_live && !sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

    typedef struct {
        bit          wr;
        logic [16:0] word;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_stall;
        int          exp_we;
        bit          b2b;
    } item_t;

    item_t       q[$];
    int          total = 0;
    int          bad = 0;

    // Reference model state: whole 32-bit words plus the read-buffer tag.
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = '0;
    bit          buf_valid = 1'b0;
    logic [16:0] buf_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] a);
        logic [31:0] o;
        o = (a - 32'd1024) / 4;
        return o[16:0];
    endfunction

    // Monitor: a rising ready after a stall marks DONE.
    bit    mon_en = 1'b0;
    bit    prev_ready = 1'b1;
    int    cyc = 0;
    int    start_cyc = 0;
    int    last_done = -100;
    int    stall = 0;
    int    we_low = 0;
    int    viol = 0;
    item_t it;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (!ready) begin
                if (prev_ready) start_cyc = cyc;
                stall++;
                if (!sram_we_n) we_low++;
                if (q.size() > 0) begin
                    if (!q[0].wr && (sram_dq_oe || !sram_we_n)) viol++;
                    if (q[0].wr && !sram_we_n && !sram_dq_oe) viol++;
                end
            end else if (!prev_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(q.size()), 32'd1);
                end else begin
                    it = q.pop_front();
                    chk("rdata", rdata, it.exp_rdata);
                    chk("stall_len", 32'(stall), 32'(it.exp_stall));
                    chk("we_low_cycles", 32'(we_low), 32'(it.exp_we));
                    chk("oe_we_pattern", 32'(viol), 32'd0);
                    if (it.wr) begin
                        chk("sram_lo", {16'h0, sram_mem[{it.word, 1'b0}]}, {16'h0, it.wdata[15:0]});
                        chk("sram_hi", {16'h0, sram_mem[{it.word, 1'b1}]}, {16'h0, it.wdata[31:16]});
                    end
                    if (it.b2b) chk("b2b_start", 32'(start_cyc), 32'(last_done + 1));
                    last_done = cyc;
                end
                stall  = 0;
                we_low = 0;
                viol   = 0;
            end
            prev_ready = ready;
        end
    end

    // Call just after a posedge with the DUT in IDLE; returns just after the edge leaving DONE.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input bit b2b);
        item_t x;
        int    n;
        x.wr    = wr;
        x.word  = word_of(a);
        x.wdata = d;
        x.b2b   = b2b;
        if (wr) begin
            ref_mem[int'(x.word)] = d;
            x.exp_stall = 2 * AC + 1;
            x.exp_we    = 2 * AC;
        end else begin
            x.exp_stall = (BufEn && buf_valid && buf_word == x.word) ? 1 : 2 * AC + 1;
            x.exp_we    = 0;
            last_rd     = ref_mem.exists(int'(x.word)) ? ref_mem[int'(x.word)] : 32'h0;
            buf_valid   = 1'b1;
            buf_word    = x.word;
        end
        x.exp_rdata = last_rd;
        q.push_back(x);
        rd_en = rd;
        wr_en = wr;
        addr  = a;
        wdata = d;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (ready) break;
            if (n > 60) begin
                chk("access_timeout", 32'(n), 32'(2 * AC + 1));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle(input int n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_run(input int count);
        bit          b2b;
        int          kind;
        logic [31:0] a;
        b2b = 1'b0;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 4) == 0) a = $urandom();
            else a = 32'd1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            kind = $urandom_range(0, 4);
            if (kind < 2)       access(1'b1, 1'b0, a, $urandom(), b2b);
            else if (kind < 4)  access(1'b0, 1'b1, a, $urandom(), b2b);
            else                access(1'b1, 1'b1, a, $urandom(), b2b);
            b2b = $urandom_range(0, 1) == 1;
            if (!b2b) go_idle($urandom_range(1, 3));
        end
        go_idle(1);
    endtask

    int          idle_viol;
    logic [31:0] rw_data;

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'd1);
        chk("rst_we_n", {31'h0, sram_we_n}, 32'd1);
        chk("rst_oe", {31'h0, sram_dq_oe}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", {16'h0, sram_dq_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sram_live = 1'b1;

        idle_viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (!ready || !sram_we_n || sram_dq_oe) idle_viol++;
        end
        chk("idle_quiet", 32'(idle_viol), 32'd0);

        mon_en = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
        go_idle(2);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        go_idle(2);
        access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        access(1'b0, 1'b1, 32'd1036, 32'h12345678, 1'b1);
        go_idle(2);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
        access(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, 1'b1);
        access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
        go_idle(2);

        random_run(150);

        // Reset during the first HI cycle of a store.
        mon_en  = 1'b0;
        rw_data = $urandom();
        wr_en   = 1'b1;
        addr    = 32'd1040;
        wdata   = rw_data;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_ready", {31'h0, ready}, 32'd0);
        chk("rstmid_we_n", {31'h0, sram_we_n}, 32'd1);
        chk("rstmid_oe", {31'h0, sram_dq_oe}, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        wr_en = 1'b0;
        #1;
        chk("rstmid_ready_idle", {31'h0, ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Both halves were strobed before the reset edge took effect.
        ref_mem[int'(word_of(32'd1040))] = rw_data;
        last_rd    = 32'h0;
        buf_valid  = 1'b0;
        prev_ready = 1'b1;
        stall      = 0;
        we_low     = 0;
        viol       = 0;
        mon_en     = 1'b1;
        go_idle(1);
        access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
        go_idle(1);

        random_run(20);
        go_idle(3);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
